imem_fill_responder: RTL and testbench
======================================

Name: imem_fill_responder

Overview:
- Memory-side responder for instruction-cache line fills.
- Accepts one-word read requests (request valid plus byte address) from the cache's miss engine.
- Returns each word after a programmable latency; the first word of a sequence costs FIRST_LATENCY, sequential follow-on words cost BURST_LATENCY.
- Backed by an internal word RAM, filled through a separate load port (boot loader / bench).

Parameters:
DATA_WIDTH, 32, word width
ADDRESS_WIDTH, 32, request byte-address width
MEM_DEPTH_WIDTH, 12, log2 of RAM depth in words
BLOCK_OFFSET_WIDTH, 6, log2 of cache line bytes (sequential detection stays inside a line)
FIRST_LATENCY, 4, edges from acceptance to response, non-sequential access (>=1)
BURST_LATENCY, 1, edges from acceptance to response, sequential access (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
i_req_valid  in  1  read request held high by cache while it wants a word
i_req_address  in  ADDRESS_WIDTH  byte address of requested word
o_resp_valid  out  1  one-cycle pulse: o_resp_data valid
o_resp_data  out  DATA_WIDTH  returned word
o_busy  out  1  high in WAIT or RESP
i_ld_we  in  1  load-port write enable
i_ld_address  in  ADDRESS_WIDTH  load byte address
i_ld_data  in  DATA_WIDTH  load data

Behaviour:
- Reset (rst low, asynchronous):
  - State IDLE; o_resp_valid=0, o_resp_data=0, o_busy=0.
  - Latency counter=0, seq flag=0.
  - RAM contents not cleared.
- Word index = address[MEM_DEPTH_WIDTH+1:2]. Bits [1:0] ignored. Upper bits ignored (address wraps modulo RAM size). Same rule for load port.
- States: IDLE, WAIT, RESP.
- IDLE:
  - i_req_valid high at an edge -> accept: latch address, go to WAIT.
  - Latency L = BURST_LATENCY if seq flag=1, latched address == last served address+4, and both are in the same BLOCK_OFFSET_WIDTH line; otherwise L = FIRST_LATENCY.
  - Counter loaded with L-1.
  - i_req_valid low at an edge in IDLE -> seq flag cleared.
- WAIT:
  - i_req_valid low at an edge -> abort: back to IDLE, no response, seq flag cleared.
  - Otherwise counter decrements; at the edge where counter==0: read RAM[latched index] into o_resp_data, set o_resp_valid=1, go to RESP.
  - Net timing: o_resp_valid rises exactly L edges after the accepting edge.
  - i_req_address changes during WAIT are ignored (latched copy used).
- RESP (exactly one cycle):
  - o_resp_valid=1.
  - Next edge: o_resp_valid=0, record served address, seq flag=1, go to IDLE unconditionally. i_req_valid is not sampled in RESP, because the cache advances its address on that edge.
  - Sustained burst throughput: one word per L+2 cycles.
- o_resp_data holds its last value until the next response or reset.
- Load port:
  - Write RAM[ld index] at any edge where i_ld_we=1, in any state.
  - Collision (write and response read of the same word on the same edge): response returns OLD data (read-before-write).
  - A write at an earlier edge is visible to a later response.
- Reset mid-WAIT/RESP: immediate return to IDLE with outputs cleared. After release, no response for the aborted request; the next access uses FIRST_LATENCY.
- FIRST_LATENCY or BURST_LATENCY = 0 is illegal; flag with a simulation $display at time 0.

Test Plan:
- Single read: RAM[0x10>>2]=0x00A00093 preloaded; i_req_valid=1, addr 0x10 accepted at edge E -> o_resp_valid pulse after edge E+4, o_resp_data=0x00A00093, o_busy low after E+5.
- Sequential line fill: preload 16 words at 0x40..0x7C with value=address; cache-model requests 0x40, 0x44, ... -> first word latency 4, next 15 words latency 1, one word per 3 cycles, data matches addresses, no extra or missing pulses.
- Line-boundary / non-sequential: after serving 0x7C, request 0x80 -> latency 4; after 0x44, request 0x4C -> latency 4; idle cycle between 0x48 and 0x4C requests -> latency 4.
- Abort: request 0x20, drop i_req_valid after 2 cycles -> no o_resp_valid; next request 0x24 takes latency 4.
- Load collision: write 0xDEADBEEF to 0x30 on the response edge of a 0x30 read with old value 0x11111111 -> response 0x11111111; immediate re-read returns 0xDEADBEEF.
- Reset mid-WAIT: assert rst low asynchronously between edges during WAIT -> o_busy, o_resp_valid, o_resp_data drop to 0 at once; no pulse after release; RAM preload still intact on the next read.

Source files
------------

// File: rtl/imem_fill_responder.sv
// Memory-side responder for instruction-cache line fills.
// Serves one word per request after a programmable latency. A follow-on
// request to the next word of the same cache line costs BURST_LATENCY edges.
// Any other request costs FIRST_LATENCY edges. A separate load port fills
// the word RAM.
module imem_fill_responder #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDRESS_WIDTH      = 32,
  parameter int MEM_DEPTH_WIDTH    = 12,
  parameter int BLOCK_OFFSET_WIDTH = 6,
  parameter int FIRST_LATENCY      = 4,
  parameter int BURST_LATENCY      = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req_valid,
  input  logic [ADDRESS_WIDTH-1:0] i_req_address,
  output logic                     o_resp_valid,
  output logic [DATA_WIDTH-1:0]    o_resp_data,
  output logic                     o_busy,
  input  logic                     i_ld_we,
  input  logic [ADDRESS_WIDTH-1:0] i_ld_address,
  input  logic [DATA_WIDTH-1:0]    i_ld_data
);

  localparam int MEM_DEPTH = 1 << MEM_DEPTH_WIDTH;
  localparam int LAT_MAX   = (FIRST_LATENCY > BURST_LATENCY) ? FIRST_LATENCY : BURST_LATENCY;
  localparam int CNT_W     = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  // A zero latency cannot be expressed by the WAIT countdown.
  if (FIRST_LATENCY < 1 || BURST_LATENCY < 1) begin : g_bad_latency
    $error("imem_fill_responder: FIRST_LATENCY and BURST_LATENCY must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                   state, state_next;
  logic [CNT_W-1:0]         cnt, cnt_next;
  logic                     seq, seq_next;
  logic [ADDRESS_WIDTH-1:0] req_addr, req_addr_next;
  logic [ADDRESS_WIDTH-1:0] last_addr, last_addr_next;
  logic                     do_read;
  logic                     is_seq;
  logic [DATA_WIDTH-1:0]    mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]    resp_data;

  // Only the word-index bits of the load address select a RAM word.
  logic unused_ld_bits;
  assign unused_ld_bits = ^{i_ld_address[ADDRESS_WIDTH-1:MEM_DEPTH_WIDTH+2],
                            i_ld_address[1:0]};

  // A request is sequential only if it directly follows the last served word.
  // It must also stay inside the same cache line.
  assign is_seq = seq
               && (i_req_address == last_addr + ADDRESS_WIDTH'(4))
               && (i_req_address[ADDRESS_WIDTH-1:BLOCK_OFFSET_WIDTH]
                   == last_addr[ADDRESS_WIDTH-1:BLOCK_OFFSET_WIDTH]);

  // Next-state logic: accept, count down, respond for one cycle, or abort.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_next     = state;
    cnt_next       = cnt;
    seq_next       = seq;
    req_addr_next  = req_addr;
    last_addr_next = last_addr;
    do_read        = 1'b0;
    case (state)
      IDLE: begin
        if (i_req_valid) begin
          req_addr_next = i_req_address;
          cnt_next      = is_seq ? CNT_W'(BURST_LATENCY - 1) : CNT_W'(FIRST_LATENCY - 1);
          state_next    = WAIT;
        end else begin
          seq_next = 1'b0;
        end
      end
      WAIT: begin
        if (!i_req_valid) begin
          seq_next   = 1'b0;
          state_next = IDLE;
        end else if (cnt == '0) begin
          do_read    = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        // The cache changes its address on this edge, so the request is not sampled here.
        last_addr_next = req_addr;
        seq_next       = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state and response data register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments. The RAM read below
    // therefore sees pre-edge contents, which gives read-before-write on a collision.
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      seq       <= 1'b0;
      req_addr  <= '0;
      last_addr <= '0;
      resp_data <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      seq       <= seq_next;
      req_addr  <= req_addr_next;
      last_addr <= last_addr_next;
      if (do_read) begin
        resp_data <= mem[req_addr[MEM_DEPTH_WIDTH+1:2]];
      end
    end
  end

  // Load-port write into the word RAM, accepted in any state.
  always_ff @(posedge clk) begin
    // NOTE: the RAM has no reset. Its contents must survive a reset of the control logic.
    if (i_ld_we) begin
      mem[i_ld_address[MEM_DEPTH_WIDTH+1:2]] <= i_ld_data;
    end
  end

  assign o_resp_valid = (state == RESP);
  assign o_busy       = (state != IDLE);
  assign o_resp_data  = resp_data;

endmodule

// File: tb/tb_imem_fill_responder.sv
// Directed self-checking bench for imem_fill_responder.
module tb_imem_fill_responder;

  logic        clk;
  logic        rst_n;
  logic        i_req_valid;
  logic [31:0] i_req_address;
  logic        o_resp_valid;
  logic [31:0] o_resp_data;
  logic        o_busy;
  logic        i_ld_we;
  logic [31:0] i_ld_address;
  logic [31:0] i_ld_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int prev_resp_cyc;
  int last_resp_cyc;

  imem_fill_responder dut (
    .clk           (clk),
    .rst           (rst_n),
    .i_req_valid   (i_req_valid),
    .i_req_address (i_req_address),
    .o_resp_valid  (o_resp_valid),
    .o_resp_data   (o_resp_data),
    .o_busy        (o_busy),
    .i_ld_we       (i_ld_we),
    .i_ld_address  (i_ld_address),
    .i_ld_data     (i_ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter, used to measure burst spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld_write(input logic [31:0] addr, input logic [31:0] data);
    i_ld_we      = 1'b1;
    i_ld_address = addr;
    i_ld_data    = data;
    tick();
    i_ld_we = 1'b0;
  endtask

  // Hold the request low for n edges and confirm that no response pulse appears.
  task automatic idle(input int n, input string tag);
    int pulses;
    pulses      = 0;
    i_req_valid = 1'b0;
    repeat (n) begin
      tick();
      if (o_resp_valid) pulses++;
    end
    check({tag, " pulses"}, 32'(pulses), 32'd0);
  endtask

  // Issue one request the way the cache does.
  // If a response is being shown, the first edge is the RESP edge, which does
  // not sample the request.
  // Then measure the edges from acceptance to the response and check the data.
  task automatic req(input logic [31:0] addr, input logic [31:0] exp_data,
                     input int exp_lat, input string tag);
    int lat;
    bit got;
    i_req_valid   = 1'b1;
    i_req_address = addr;
    if (o_resp_valid) tick();
    tick();
    check({tag, " busy"}, 32'(o_busy), 32'd1);
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      tick();
      lat++;
      if (o_resp_valid) got = 1;
    end
    check({tag, " lat"}, 32'(lat), 32'(exp_lat));
    check({tag, " data"}, o_resp_data, exp_data);
    prev_resp_cyc = last_resp_cyc;
    last_resp_cyc = cyc;
  endtask

  initial begin
    rst_n         = 1'b0;
    i_req_valid   = 1'b0;
    i_req_address = '0;
    i_ld_we       = 1'b0;
    i_ld_address  = '0;
    i_ld_data     = '0;
    prev_resp_cyc = 0;
    last_resp_cyc = 0;

    // Reset state.
    #12;
    check("rst busy", 32'(o_busy), 32'd0);
    check("rst valid", 32'(o_resp_valid), 32'd0);
    check("rst data", o_resp_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // Preload the RAM through the load port.
    ld_write(32'h10, 32'h00A00093);
    for (int a = 32'h40; a <= 32'h80; a += 4) ld_write(32'(a), 32'(a));
    ld_write(32'h20, 32'h20202020);
    ld_write(32'h24, 32'h24242424);
    ld_write(32'h30, 32'h11111111);
    idle(2, "preload");

    // Single read: pulse L=4 edges after acceptance, then idle on the next edge.
    req(32'h10, 32'h00A00093, 4, "single");
    i_req_valid = 1'b0;
    tick();
    check("single valid drop", 32'(o_resp_valid), 32'd0);
    check("single busy drop", 32'(o_busy), 32'd0);
    idle(2, "single idle");

    // Sequential line fill: first word costs 4 edges, the next 15 cost 1 edge each, one word per 3 edges.
    req(32'h40, 32'h40, 4, "fill first");
    for (int i = 1; i < 16; i++) begin
      req(32'(32'h40 + 4 * i), 32'(32'h40 + 4 * i), 1, $sformatf("fill w%0d", i));
      check($sformatf("fill gap w%0d", i), 32'(last_resp_cyc - prev_resp_cyc), 32'd3);
    end
    // 0x80 follows 0x7C but lies in the next line, so it costs the first latency.
    req(32'h80, 32'h80, 4, "line cross");
    idle(2, "after fill");

    // Non-sequential and idle-broken sequences.
    req(32'h44, 32'h44, 4, "ns 44");
    req(32'h4C, 32'h4C, 4, "ns 4c");
    idle(2, "ns gap");
    req(32'h44, 32'h44, 4, "seq 44");
    req(32'h48, 32'h48, 1, "seq 48");
    idle(2, "idle gap");
    req(32'h4C, 32'h4C, 4, "after idle 4c");
    idle(2, "ns idle");

    // Abort: serve 0x20, start a second 0x20, then drop the request two cycles into WAIT.
    // The following 0x24 must not be treated as sequential.
    req(32'h20, 32'h20202020, 4, "pre abort");
    i_req_address = 32'h20;
    tick();
    tick();
    tick();
    tick();
    i_req_valid = 1'b0;
    tick();
    check("abort busy", 32'(o_busy), 32'd0);
    check("abort valid", 32'(o_resp_valid), 32'd0);
    req(32'h24, 32'h24242424, 4, "post abort");
    idle(2, "abort idle");

    // Load collision on the response edge: the old value is returned.
    i_req_valid   = 1'b1;
    i_req_address = 32'h30;
    tick();
    tick();
    tick();
    tick();
    i_ld_we      = 1'b1;
    i_ld_address = 32'h30;
    i_ld_data    = 32'hDEADBEEF;
    tick();
    i_ld_we = 1'b0;
    check("collide valid", 32'(o_resp_valid), 32'd1);
    check("collide data", o_resp_data, 32'h11111111);
    req(32'h30, 32'hDEADBEEF, 4, "reread");
    idle(2, "reread idle");

    // Asynchronous reset in the middle of WAIT.
    i_req_valid   = 1'b1;
    i_req_address = 32'h10;
    tick();
    tick();
    check("mid wait busy", 32'(o_busy), 32'd1);
    #2;
    rst_n       = 1'b0;
    i_req_valid = 1'b0;
    #1;
    check("async rst busy", 32'(o_busy), 32'd0);
    check("async rst valid", 32'(o_resp_valid), 32'd0);
    check("async rst data", o_resp_data, 32'd0);
    #10;
    rst_n = 1'b1;
    idle(6, "post rst");
    req(32'h10, 32'h00A00093, 4, "post rst read");
    idle(2, "final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
